mixed_cycle_csr: RTL and testbench

- CSR-side endpoint of the mixed-precision dot-product sequencing path.
- Holds the mixed-precision cycle register (CSR 0x00D), the skip-size register (CSR 0x00E) and a read-only wrap counter (CSR 0x00F).
- Accepts hardware cycle updates from the ID-stage controller (next_cycle / write-enable pair) and software CSR accesses.
- Returns current_cycle and skip_size to the controller and cycle selection to the EX-stage operand slicer.

---
 rtl/mixed_cycle_csr.sv | 153 +++++++++++++++
 tb/tb_mixed_cycle_csr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mixed_cycle_csr.sv
// rtl/mixed_cycle_csr.sv - mixed-precision cycle / skip-size / wrap-count CSR endpoint
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ivec_fmt_i        current vector format (fmt_q tracks it every cycle)
//   hw_we_i           hardware cycle write strobe from the ID-stage controller
//   hw_cycle_i        hardware next cycle value
//   csr_op_i          00 none, 01 write, 10 set, 11 clear
//   csr_addr_i        CSR address (0x00D cycle, 0x00E skip, 0x00F wrap count)
//   csr_wdata_i       CSR write data / mask
//   csr_rdata_o       combinational read data (pre-write value)
//   csr_hit_o         address decodes to one of the three CSRs
//   current_cycle_o   registered cycle to the controller
//   cycle_fwd_o       same-cycle forwarded cycle for the EX operand slicer
//   skip_size_o       registered skip size
//   wrap_o            one-cycle pulse after a group completes

package mixed_cycle_csr_pkg;
    typedef enum logic [3:0] {
        FMT_8      = 4'd0,
        FMT_16     = 4'd1,
        FMT_32     = 4'd2,
        MIXED_2x4  = 4'd3,
        MIXED_2x8  = 4'd4,
        MIXED_2x16 = 4'd5,
        MIXED_4x8  = 4'd6,
        MIXED_4x16 = 4'd7,
        MIXED_8x16 = 4'd8
    } ivec_mode_fmt;
endpackage

module mixed_cycle_csr
    import mixed_cycle_csr_pkg::*;
#(
    parameter int NBITS_MIXED_CYCLES = 3,
    parameter int NBITS_MAX_KER      = 8,
    parameter int WRAP_CNT_W         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  ivec_mode_fmt                  ivec_fmt_i,
    input  logic                          hw_we_i,
    input  logic [NBITS_MIXED_CYCLES-1:0] hw_cycle_i,
    input  logic [1:0]                    csr_op_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic [31:0]                   csr_rdata_o,
    output logic                          csr_hit_o,
    output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
    output logic [NBITS_MIXED_CYCLES-1:0] cycle_fwd_o,
    output logic [NBITS_MAX_KER-1:0]      skip_size_o,
    output logic                          wrap_o
);

    localparam logic [11:0] ADDR_CYCLE = 12'h00D;
    localparam logic [11:0] ADDR_SKIP  = 12'h00E;
    localparam logic [11:0] ADDR_WRAP  = 12'h00F;

    logic [NBITS_MIXED_CYCLES-1:0] cycle_q;
    logic [NBITS_MAX_KER-1:0]      skip_q;
    logic [WRAP_CNT_W-1:0]         wrap_cnt_q;
    logic                          wrap_q;
    ivec_mode_fmt                  fmt_q;

    // Highest legal cycle index for a format; doubles as the mask that keeps
    // cycle_q inside the group (all zero for non-mixed formats).
    function automatic logic [NBITS_MIXED_CYCLES-1:0] max_cycle(input ivec_mode_fmt f);
        case (f)
            MIXED_2x4, MIXED_4x8, MIXED_8x16: return NBITS_MIXED_CYCLES'(1);
            MIXED_2x8, MIXED_4x16:            return NBITS_MIXED_CYCLES'(3);
            MIXED_2x16:                       return NBITS_MIXED_CYCLES'(7);
            default:                          return '0;
        endcase
    endfunction

    // Generic 32-bit write/set/clear; callers truncate to register width.
    function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old,
                                              input logic [31:0] wd);
        case (op)
            2'b01:   return wd;
            2'b10:   return old | wd;
            2'b11:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    logic                          fmt_change;
    logic                          sw_cyc;
    logic                          sw_skip;
    logic                          hw_acc;
    logic                          hw_wrap;
    logic [NBITS_MIXED_CYCLES-1:0] maxc;
    logic [NBITS_MIXED_CYCLES-1:0] hw_masked;
    logic [NBITS_MIXED_CYCLES-1:0] cyc_w;
    logic [NBITS_MAX_KER-1:0]      skip_w;

    assign fmt_change = (ivec_fmt_i != fmt_q);
    assign sw_cyc     = (csr_op_i != 2'b00) && (csr_addr_i == ADDR_CYCLE);
    assign sw_skip    = (csr_op_i != 2'b00) && (csr_addr_i == ADDR_SKIP);
    assign maxc       = max_cycle(ivec_fmt_i);
    assign hw_masked  = hw_cycle_i & maxc;
    assign cyc_w      = NBITS_MIXED_CYCLES'(csr_apply(csr_op_i, 32'(cycle_q), csr_wdata_i));
    assign skip_w     = NBITS_MAX_KER'(csr_apply(csr_op_i, 32'(skip_q), csr_wdata_i));

    // A hardware write only lands when neither a format change nor a software
    // cycle write outranks it; only a landed write can signal a wrap.
    assign hw_acc  = hw_we_i && !fmt_change && !sw_cyc;
    assign hw_wrap = hw_acc && (hw_masked == '0) && (cycle_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q    <= '0;
            skip_q     <= NBITS_MAX_KER'(1);
            wrap_cnt_q <= '0;
            wrap_q     <= 1'b0;
            fmt_q      <= ivec_fmt_i;
        end else begin
            fmt_q  <= ivec_fmt_i;
            wrap_q <= hw_wrap;
            if (fmt_change) begin
                cycle_q <= '0;
            end else if (sw_cyc) begin
                cycle_q <= cyc_w & maxc;
            end else if (hw_we_i) begin
                cycle_q <= hw_masked;
            end
            if (hw_wrap) begin
                wrap_cnt_q <= wrap_cnt_q + WRAP_CNT_W'(1);
            end
            // A skip of zero would stall the kernel walk, so it is stored as 1.
            if (sw_skip) begin
                skip_q <= (skip_w == '0) ? NBITS_MAX_KER'(1) : skip_w;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        csr_hit_o   = 1'b0;
        case (csr_addr_i)
            ADDR_CYCLE: begin csr_rdata_o = 32'(cycle_q);    csr_hit_o = 1'b1; end
            ADDR_SKIP:  begin csr_rdata_o = 32'(skip_q);     csr_hit_o = 1'b1; end
            ADDR_WRAP:  begin csr_rdata_o = 32'(wrap_cnt_q); csr_hit_o = 1'b1; end
            default:    begin csr_rdata_o = '0;              csr_hit_o = 1'b0; end
        endcase
    end

    assign current_cycle_o = cycle_q;
    assign cycle_fwd_o     = hw_acc ? hw_masked : cycle_q;
    assign skip_size_o     = skip_q;
    assign wrap_o          = wrap_q;

endmodule

// File: tb/tb_mixed_cycle_csr.sv
// tb/tb_mixed_cycle_csr.sv - self-checking bench for mixed_cycle_csr
module tb_mixed_cycle_csr;
    import mixed_cycle_csr_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    ivec_mode_fmt ivec_fmt = MIXED_2x8;
    logic         hw_we = 1'b0;
    logic [2:0]   hw_cycle = '0;
    logic [1:0]   csr_op = '0;
    logic [11:0]  csr_addr = '0;
    logic [31:0]  csr_wdata = '0;
    logic [31:0]  csr_rdata;
    logic         csr_hit;
    logic [2:0]   current_cycle;
    logic [2:0]   cycle_fwd;
    logic [7:0]   skip_size;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    mixed_cycle_csr dut (
        .clk             (clk),
        .rst             (rst),
        .ivec_fmt_i      (ivec_fmt),
        .hw_we_i         (hw_we),
        .hw_cycle_i      (hw_cycle),
        .csr_op_i        (csr_op),
        .csr_addr_i      (csr_addr),
        .csr_wdata_i     (csr_wdata),
        .csr_rdata_o     (csr_rdata),
        .csr_hit_o       (csr_hit),
        .current_cycle_o (current_cycle),
        .cycle_fwd_o     (cycle_fwd),
        .skip_size_o     (skip_size),
        .wrap_o          (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cycle, m_skip;
    logic [31:0] m_wrapcnt;
    int          m_wrap;
    ivec_mode_fmt m_fmt;
    bit          mv = 0;

    function automatic int group_max(input ivec_mode_fmt f);
        // number of chunks in a mixed group minus one
        if (f == MIXED_2x16) return 7;
        if (f == MIXED_2x8 || f == MIXED_4x16) return 3;
        if (f == MIXED_2x4 || f == MIXED_4x8 || f == MIXED_8x16) return 1;
        return 0;
    endfunction

    function automatic int op_result(input int op, input int old, input logic [31:0] wd);
        logic [31:0] o;
        o = 32'(old);
        if (op == 1) return int'(wd);
        if (op == 2) return int'(o | wd);
        if (op == 3) return int'(o & ~wd);
        return old;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cycle = 0; m_skip = 1; m_wrapcnt = 0; m_wrap = 0; m_fmt = ivec_fmt; mv = 1;
        end else if (mv) begin
            int lim, nv, s;
            bit sw_on, nw;
            lim   = group_max(ivec_fmt);
            sw_on = (csr_op != 0);
            nw    = 0;
            if (sw_on && csr_addr == 12'h00E) begin
                s = op_result(csr_op, m_skip, csr_wdata) % 256;
                m_skip = (s == 0) ? 1 : s;
            end
            if (ivec_fmt != m_fmt) m_cycle = 0;
            else if (sw_on && csr_addr == 12'h00D)
                m_cycle = (op_result(csr_op, m_cycle, csr_wdata) % 8) & lim;
            else if (hw_we) begin
                nv = int'(hw_cycle) & lim;
                if (nv == 0 && m_cycle != 0) begin nw = 1; m_wrapcnt = m_wrapcnt + 1; end
                m_cycle = nv;
            end
            m_fmt  = ivec_fmt;
            m_wrap = nw ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            int e_fwd;
            logic [31:0] e_rd;
            e_fwd = m_cycle;
            if (!rst && hw_we && ivec_fmt == m_fmt && !(csr_op != 0 && csr_addr == 12'h00D))
                e_fwd = int'(hw_cycle) & group_max(ivec_fmt);
            e_rd = 0;
            if (csr_addr == 12'h00D) e_rd = 32'(m_cycle);
            if (csr_addr == 12'h00E) e_rd = 32'(m_skip);
            if (csr_addr == 12'h00F) e_rd = m_wrapcnt;
            chk("model_cycle", 32'(current_cycle), 32'(m_cycle));
            chk("model_skip",  32'(skip_size),     32'(m_skip));
            chk("model_wrap",  32'(wrap),          32'(m_wrap));
            chk("model_rdata", csr_rdata,          e_rd);
            chk("model_hit",   32'(csr_hit),       32'(csr_addr >= 12'h00D && csr_addr <= 12'h00F));
            if (!rst) chk("model_fwd", 32'(cycle_fwd), 32'(e_fwd));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [2:0]  fwd_seen;
    logic [31:0] rd_seen;

    task automatic cyc(input ivec_mode_fmt f, input logic we, input logic [2:0] hc,
                       input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        ivec_fmt = f; hw_we = we; hw_cycle = hc; csr_op = op; csr_addr = a; csr_wdata = wd;
        #1;
        fwd_seen = cycle_fwd;
        rd_seen  = csr_rdata;
        @(posedge clk); #1;
        hw_we = 0; hw_cycle = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    endtask

    initial begin
        // 1: reset, then a full 2x8 group
        rst = 1; ivec_fmt = MIXED_2x8;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        chk("rst_cycle", 32'(current_cycle), 0);
        chk("rst_skip",  32'(skip_size), 1);
        chk("rst_wrap",  32'(wrap), 0);
        cyc(MIXED_2x8, 1, 3'd1, 0, 0, 0); chk("t1_c1", 32'(current_cycle), 1);
        cyc(MIXED_2x8, 1, 3'd2, 0, 0, 0); chk("t1_c2", 32'(current_cycle), 2);
        cyc(MIXED_2x8, 1, 3'd3, 0, 0, 0); chk("t1_c3", 32'(current_cycle), 3);
        chk("t1_nowrap", 32'(wrap), 0);
        cyc(MIXED_2x8, 1, 3'd0, 0, 0, 0); chk("t1_c0", 32'(current_cycle), 0);
        chk("t1_wrap", 32'(wrap), 1);
        cyc(MIXED_2x8, 0, 0, 0, 12'h00F, 0);
        chk("t1_wrapcnt", rd_seen, 1);
        chk("t1_wrap_pulse", 32'(wrap), 0);

        // 2: masking and set/clear on 2x4
        cyc(MIXED_2x4, 0, 0, 0, 0, 0);            chk("t2_fmt", 32'(current_cycle), 0);
        cyc(MIXED_2x4, 0, 0, 1, 12'h00D, 7);      chk("t2_wr",  32'(current_cycle), 1);
        cyc(MIXED_2x4, 0, 0, 2, 12'h00D, 0);      chk("t2_set", 32'(current_cycle), 1);
        cyc(MIXED_2x4, 0, 0, 3, 12'h00D, 1);      chk("t2_clr", 32'(current_cycle), 0);

        // 3: sw write beats hw write in the same cycle
        cyc(MIXED_2x16, 0, 0, 0, 0, 0);
        cyc(MIXED_2x16, 1, 3'd5, 0, 0, 0);        chk("t3_pre", 32'(current_cycle), 5);
        cyc(MIXED_2x16, 1, 3'd3, 1, 12'h00D, 2);
        chk("t3_fwd", 32'(fwd_seen), 5);
        chk("t3_cyc", 32'(current_cycle), 2);
        chk("t3_nowrap", 32'(wrap), 0);

        // 4: format change beats a hw wrap
        cyc(MIXED_2x16, 1, 3'd5, 0, 0, 0);        chk("t4_pre", 32'(current_cycle), 5);
        cyc(MIXED_4x16, 1, 3'd0, 0, 0, 0);
        chk("t4_cyc", 32'(current_cycle), 0);
        chk("t4_nowrap", 32'(wrap), 0);
        cyc(MIXED_4x16, 0, 0, 0, 12'h00F, 0);     chk("t4_cnt", rd_seen, 1);

        // 5: skip register and read-only wrap counter
        cyc(MIXED_4x16, 0, 0, 1, 12'h00E, 0);     chk("t5_skip0", 32'(skip_size), 1);
        cyc(MIXED_4x16, 0, 0, 1, 12'h00E, 32'h1FF); chk("t5_skipff", 32'(skip_size), 8'hFF);
        cyc(MIXED_4x16, 0, 0, 1, 12'h00F, 5);
        cyc(MIXED_4x16, 0, 0, 0, 12'h00F, 0);     chk("t5_ro", rd_seen, 1);
        cyc(MIXED_4x16, 0, 0, 0, 12'h00E, 0);     chk("t5_rdskip", rd_seen, 32'hFF);

        // non-mixed format forces zero
        cyc(FMT_16, 1, 3'd3, 0, 0, 0);
        cyc(FMT_16, 1, 3'd3, 0, 0, 0);
        chk("nm_fwd", 32'(fwd_seen), 0);
        chk("nm_cyc", 32'(current_cycle), 0);

        // 6: reset wins over concurrent sw write and hw wrap
        cyc(MIXED_2x8, 0, 0, 0, 0, 0);
        cyc(MIXED_2x8, 1, 3'd2, 0, 0, 0);         chk("t6_pre", 32'(current_cycle), 2);
        rst = 1; hw_we = 1; hw_cycle = 0; csr_op = 1; csr_addr = 12'h00D; csr_wdata = 3;
        @(posedge clk); #1;
        rst = 0; hw_we = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        chk("t6_cyc",  32'(current_cycle), 0);
        chk("t6_skip", 32'(skip_size), 1);
        chk("t6_wrap", 32'(wrap), 0);
        cyc(MIXED_2x8, 0, 0, 0, 12'h00F, 0);      chk("t6_cnt", rd_seen, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
